// File: rtl/clk_ratio_detector.sv
// Measures period and high time of a divided clock generated in the clk domain,
// flags even 50% divides, and tracks lock / mismatch / loss-of-signal.
module clk_ratio_detector #(
  parameter int W        = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         even,
  output logic         locked,
  output logic         err,
  output logic         timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [3:0]   LOCK_N  = 4'(LOCK_CNT);

  state_t       state_q,  state_d;
  logic         sig_q,    sig_d;
  logic [W-1:0] cnt_q,    cnt_d;
  logic [W-1:0] hcnt_q,   hcnt_d;
  logic [3:0]   match_q,  match_d;
  logic         cap_seen_q, cap_seen_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q,   high_d;
  logic         valid_q,  valid_d;
  logic         even_q,   even_d;
  logic         locked_q, locked_d;
  logic         err_q,    err_d;
  logic         timeout_q, timeout_d;

  logic         rise;
  logic         same_meas;
  logic         even_calc;
  logic [W:0]   hcnt_x2;
  logic [3:0]   match_inc;

  always_comb begin
    rise      = sig_in & ~sig_q;
    same_meas = (cnt_q == period_q) && (hcnt_q == high_q);
    hcnt_x2   = {hcnt_q, 1'b0};
    even_calc = ~cnt_q[0] && (hcnt_x2 == {1'b0, cnt_q});
    match_inc = (match_q == LOCK_N) ? match_q : match_q + 4'd1;

    state_d    = state_q;
    sig_d      = sig_in;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    match_d    = match_q;
    cap_seen_d = cap_seen_q;
    period_d   = period_q;
    high_d     = high_q;
    even_d     = even_q;
    locked_d   = locked_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    timeout_d  = 1'b0;

    if (rise) begin
      // A rise always restarts counting, even when it coincides with a timeout.
      cnt_d  = ONE;
      hcnt_d = ONE;
      if (state_q == IDLE) begin
        state_d    = MEASURE;
        cap_seen_d = 1'b0;
      end else begin
        period_d   = cnt_q;
        high_d     = hcnt_q;
        even_d     = even_calc;
        valid_d    = 1'b1;
        cap_seen_d = 1'b1;
        if (cap_seen_q) begin
          if (same_meas) begin
            match_d = match_inc;
            if (match_inc == LOCK_N) locked_d = 1'b1;
          end else begin
            match_d  = 4'd0;
            locked_d = 1'b0;
            err_d    = locked_q;
          end
        end
      end
    end else if (state_q == MEASURE) begin
      if (cnt_q == CNT_MAX) begin
        // Lost the signal: counters hold (never wrap) and all results are dropped.
        state_d    = IDLE;
        timeout_d  = 1'b1;
        period_d   = '0;
        high_d     = '0;
        even_d     = 1'b0;
        locked_d   = 1'b0;
        match_d    = 4'd0;
        cap_seen_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + ONE;
        hcnt_d = hcnt_q + {{(W-1){1'b0}}, sig_in};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sig_q      <= 1'b1;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      match_q    <= 4'd0;
      cap_seen_q <= 1'b0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      even_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      match_q    <= match_d;
      cap_seen_q <= cap_seen_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      even_q     <= even_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign even      = even_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign timeout   = timeout_q;

endmodule
